unified_mem_arbiter: RTL
========================

// Module: unified_mem_arbiter
// PURPOSE
// Shares one single-ported memory between the pipeline's instruction-fetch port and data (load/store) port.
// Sequences each access as issue -> grant -> (read response) -> completion pulse.
// The pipeline stalls on the port whose done has not yet pulsed. Data port wins by default (older instruction);
// a starvation counter guarantees fetch progress. A response watchdog flags a hung memory.
// PARAMETERS
// AW            32  address width, both requester ports and memory port
// DW            32  data width, all read/write data buses
// STARVE_LIMIT   4  max consecutive data grants while a fetch is pending; must be >=1
// TIMEOUT      256  cycles in WAIT_RD without i_mem_rvalid before error completion; must be >=2
// PORTS
// i_clk          in   1   clock, all state on rising edge
// i_rst          in   1   reset, asynchronous, active-high
// i_if_req       in   1   fetch request, held until o_if_done
// i_if_addr      in   AW  fetch address, stable while i_if_req
// o_if_done      out  1   one-cycle fetch completion pulse
// o_if_rdata     out  DW  fetch data, valid with o_if_done, held until next if completion
// i_d_req        in   1   data request, held until o_d_done
// i_d_we         in   1   1=store, 0=load; stable while i_d_req
// i_d_addr       in   AW  data address
// i_d_wdata      in   DW  store data
// o_d_done       out  1   one-cycle data completion pulse
// o_d_rdata      out  DW  load data, valid with o_d_done, held until next data completion
// o_mem_req      out  1   memory request; held until i_mem_gnt
// o_mem_we       out  1   memory write enable
// o_mem_addr     out  AW  memory address
// o_mem_wdata    out  DW  memory write data
// i_mem_gnt      in   1   memory accepts request this cycle
// i_mem_rvalid   in   1   read response valid; only meaningful in WAIT_RD
// i_mem_rdata    in   DW  read response data
// o_err          out  1   sticky watchdog error; cleared only by reset
// BEHAVIOUR
// Reset: state=IDLE; owner, streak and watchdog counters =0; all outputs 0, incl. rdata regs and o_err.
// Reset is honoured mid-transaction. A late i_mem_rvalid after reset is ignored (arrives in IDLE).
// FSM: IDLE, ISSUE, WAIT_RD, RESP. At most one memory transaction outstanding.
// IDLE: arbitrate. d_req && !(if_req && streak==STARVE_LIMIT) -> owner=D; else if_req -> owner=IF; else stay.
//   Latch owner, we, addr, wdata into issue regs (fetch: we=0). Go to ISSUE.
//   streak: D grant with if_req high -> +1 (saturating at STARVE_LIMIT); IF grant -> 0; D grant, if_req low -> 0.
// ISSUE: o_mem_req=1, we/addr/wdata from issue regs. Outputs stable until i_mem_gnt.
//   gnt&&we -> RESP. gnt&&!we -> WAIT_RD, watchdog=0. No gnt -> stay, no timeout in ISSUE.
// WAIT_RD: o_mem_req=0. rvalid -> capture i_mem_rdata into owner's rdata reg, go to RESP.
//   Else watchdog +1. When watchdog==TIMEOUT-1 without rvalid: owner rdata=0, o_err=1, go to RESP.
// RESP: owner's done=1 for exactly this cycle; other done=0. Go to IDLE.
// Requester rule: req low or a new request in the cycle after done. IDLE samples only that cycle's values.
// Timing: write = 1 (IDLE) + ISSUE cycles + 1 (RESP). Zero-wait gnt -> done 3rd cycle after req seen in IDLE.
// Read adds WAIT_RD cycles. rvalid the cycle after gnt -> done 4th cycle.
// Back-to-back: RESP -> IDLE -> ISSUE; minimum 3 cycles per write, 4 per read.
// Simultaneous req in IDLE: data wins unless starvation rule fires. Fetch waits <= STARVE_LIMIT data grants.
// i_mem_gnt outside ISSUE and i_mem_rvalid outside WAIT_RD are ignored.
// rdata regs hold their value across other-port completions.
// TESTING
// 1 Fetch only: if_addr=0x40, gnt immediate, rvalid+rdata=0x00000013 1 cycle later -> o_if_done on 4th cycle, o_if_rdata=0x13.
// 2 Store: d_we=1, addr=0x100, wdata=0xDEADBEEF, gnt held low 3 cycles -> o_mem_req held 4 cycles, addr/wdata stable, o_d_done after gnt.
// 3 Contention: if_req and d_req (load) held continuously, STARVE_LIMIT=4 -> grant order D,D,D,D,IF,D,D,D,D,IF.
// 4 Timeout: load, gnt, rvalid never, TIMEOUT=8 -> o_d_done 8 cycles after WAIT_RD entry, o_d_rdata=0, o_err=1 sticky.
// 5 Reset mid-WAIT_RD: assert i_rst between edges -> outputs 0 immediately. Subsequent rvalid ignored. No done pulse.
// 6 Independence: load returns 0xAAAA5555, then fetch 0x12345678 -> o_d_rdata stays 0xAAAA5555.

Source files
------------

// File: rtl/unified_mem_arbiter.sv
// unified_mem_arbiter
//   Shares one single-ported memory between the instruction-fetch port and the
//   data (load/store) port. Each access runs IDLE -> ISSUE -> (WAIT_RD) -> RESP.
//   The requester sees a one-cycle done pulse in RESP.
//   Data wins by default; a streak counter lets fetch in after STARVE_LIMIT
//   consecutive data grants. A watchdog ends a read that never gets a response
//   and raises a sticky error.
// Ports
//   i_clk, i_rst                  clock, asynchronous active-high reset
//   i_if_req/i_if_addr            fetch request and address
//   o_if_done/o_if_rdata          fetch completion pulse and held read data
//   i_d_req/i_d_we/i_d_addr/
//   i_d_wdata                     data request, store enable, address, store data
//   o_d_done/o_d_rdata            data completion pulse and held load data
//   o_mem_req/o_mem_we/
//   o_mem_addr/o_mem_wdata        memory request side
//   i_mem_gnt/i_mem_rvalid/
//   i_mem_rdata                   memory grant and read response
//   o_err                         sticky watchdog error
module unified_mem_arbiter #(
    parameter int unsigned AW           = 32,
    parameter int unsigned DW           = 32,
    parameter int unsigned STARVE_LIMIT = 4,
    parameter int unsigned TIMEOUT      = 256
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_if_req,
    input  logic [AW-1:0] i_if_addr,
    output logic          o_if_done,
    output logic [DW-1:0] o_if_rdata,
    input  logic          i_d_req,
    input  logic          i_d_we,
    input  logic [AW-1:0] i_d_addr,
    input  logic [DW-1:0] i_d_wdata,
    output logic          o_d_done,
    output logic [DW-1:0] o_d_rdata,
    output logic          o_mem_req,
    output logic          o_mem_we,
    output logic [AW-1:0] o_mem_addr,
    output logic [DW-1:0] o_mem_wdata,
    input  logic          i_mem_gnt,
    input  logic          i_mem_rvalid,
    input  logic [DW-1:0] i_mem_rdata,
    output logic          o_err
);

    localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);
    localparam int unsigned WW = $clog2(TIMEOUT);

    typedef enum logic [1:0] {StIdle, StIssue, StWaitRd, StResp} state_e;

    state_e          state_q, state_d;
    logic            owner_q, owner_d;     // 1 = data port, 0 = fetch port
    logic            we_q, we_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [DW-1:0]   wdata_q, wdata_d;
    logic [SW-1:0]   streak_q, streak_d;
    logic [WW-1:0]   wdog_q, wdog_d;
    logic [DW-1:0]   if_rdata_q, if_rdata_d;
    logic [DW-1:0]   d_rdata_q, d_rdata_d;
    logic            err_q, err_d;
    logic            mem_req_q, mem_req_d;
    logic            if_done_q, if_done_d;
    logic            d_done_q, d_done_d;
    logic            d_win;

    // Fetch only overrides data once the data streak has hit the limit.
    assign d_win = i_d_req && !(i_if_req && (streak_q == SW'(STARVE_LIMIT)));

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        streak_d   = streak_q;
        wdog_d     = wdog_q;
        if_rdata_d = if_rdata_q;
        d_rdata_d  = d_rdata_q;
        err_d      = err_q;
        mem_req_d  = mem_req_q;
        if_done_d  = 1'b0;
        d_done_d   = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (d_win) begin
                    owner_d   = 1'b1;
                    we_d      = i_d_we;
                    addr_d    = i_d_addr;
                    wdata_d   = i_d_wdata;
                    state_d   = StIssue;
                    mem_req_d = 1'b1;
                    if (!i_if_req) begin
                        streak_d = '0;
                    end else if (streak_q != SW'(STARVE_LIMIT)) begin
                        streak_d = streak_q + SW'(1);
                    end
                end else if (i_if_req) begin
                    owner_d   = 1'b0;
                    we_d      = 1'b0;
                    addr_d    = i_if_addr;
                    wdata_d   = '0;
                    state_d   = StIssue;
                    mem_req_d = 1'b1;
                    streak_d  = '0;
                end
            end
            StIssue: begin
                if (i_mem_gnt) begin
                    mem_req_d = 1'b0;
                    if (we_q) begin
                        state_d   = StResp;
                        d_done_d  = owner_q;
                        if_done_d = !owner_q;
                    end else begin
                        state_d = StWaitRd;
                        wdog_d  = '0;
                    end
                end
            end
            StWaitRd: begin
                if (i_mem_rvalid || (wdog_q == WW'(TIMEOUT - 1))) begin
                    // On timeout the owner gets zero data and the error sticks.
                    if (owner_q) begin
                        d_rdata_d = i_mem_rvalid ? i_mem_rdata : '0;
                    end else begin
                        if_rdata_d = i_mem_rvalid ? i_mem_rdata : '0;
                    end
                    err_d     = err_q | !i_mem_rvalid;
                    state_d   = StResp;
                    d_done_d  = owner_q;
                    if_done_d = !owner_q;
                end else begin
                    wdog_d = wdog_q + WW'(1);
                end
            end
            StResp: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q    <= StIdle;
            owner_q    <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            streak_q   <= '0;
            wdog_q     <= '0;
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
            err_q      <= 1'b0;
            mem_req_q  <= 1'b0;
            if_done_q  <= 1'b0;
            d_done_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            streak_q   <= streak_d;
            wdog_q     <= wdog_d;
            if_rdata_q <= if_rdata_d;
            d_rdata_q  <= d_rdata_d;
            err_q      <= err_d;
            mem_req_q  <= mem_req_d;
            if_done_q  <= if_done_d;
            d_done_q   <= d_done_d;
        end
    end

    assign o_if_done   = if_done_q;
    assign o_if_rdata  = if_rdata_q;
    assign o_d_done    = d_done_q;
    assign o_d_rdata   = d_rdata_q;
    assign o_mem_req   = mem_req_q;
    assign o_mem_we    = we_q;
    assign o_mem_addr  = addr_q;
    assign o_mem_wdata = wdata_q;
    assign o_err       = err_q;

endmodule
